// File: rtl/scan_player_pkg.sv
// rtl/scan_player_pkg.sv - shared types for the scan pattern player
package scan_player_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_MEASURE = 3'd3,
      ST_DONE    = 3'd4
   } player_state_e;

   localparam int PAT_PI_W = 5;
   localparam int PAT_PO_W = 2;

   // One entry of the pattern stream as produced by the ROM/loader.
   typedef struct packed {
      logic [PAT_PI_W-1:0] pi;
      logic [PAT_PO_W-1:0] xpct;
      logic [PAT_PO_W-1:0] mask;
      logic                last;
   } pat_rec_t;

endpackage

// File: rtl/scan_masked_cmp.sv
// rtl/scan_masked_cmp.sv - masked compare of observed vs expected outputs
module scan_masked_cmp #(
   parameter int W = 2
) (
   input  logic [W-1:0] po_i,
   input  logic [W-1:0] xpct_i,
   input  logic [W-1:0] mask_i,
   output logic [W-1:0] mism_o,
   output logic         any_fail_o
);

   assign mism_o     = (po_i ^ xpct_i) & mask_i;
   assign any_fail_o = |mism_o;

endmodule

// File: rtl/scan_pattern_player.sv
// rtl/scan_pattern_player.sv - applies ATPG vectors to a DUT and checks its outputs
module scan_pattern_player
   import scan_player_pkg::*;
#(
   parameter int NINPUTS       = PAT_PI_W,
   parameter int NOUTPUTS      = PAT_PO_W,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                pat_valid,
   output logic                pat_ready,
   input  logic [NINPUTS-1:0]  pat_pi,
   input  logic [NOUTPUTS-1:0] pat_xpct,
   input  logic [NOUTPUTS-1:0] pat_mask,
   input  logic                pat_last,
   output logic [NINPUTS-1:0]  dut_pi,
   input  logic [NOUTPUTS-1:0] dut_po,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [CNT_W-1:0]    pat_count,
   output logic [CNT_W-1:0]    fail_count,
   output logic [CNT_W-1:0]    first_fail_pat,
   output logic [NOUTPUTS-1:0] first_fail_bits
);

   localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   player_state_e        state_q;
   logic [SCNT_W-1:0]    settle_q;
   logic [NOUTPUTS-1:0]  xpct_q, mask_q, ff_bits_q;
   logic                 last_q;
   logic [NINPUTS-1:0]   dut_pi_q;
   logic [CNT_W-1:0]     pat_cnt_q, fail_cnt_q, ff_pat_q;
   logic                 busy_q, done_q, pass_q, ready_q;
   logic [NOUTPUTS-1:0]  mism;
   logic                 any_fail;
   logic [CNT_W-1:0]     fail_cnt_d;

   scan_masked_cmp #(.W(NOUTPUTS)) u_cmp (
      .po_i       (dut_po),
      .xpct_i     (xpct_q),
      .mask_i     (mask_q),
      .mism_o     (mism),
      .any_fail_o (any_fail)
   );

   assign fail_cnt_d = (any_fail && (fail_cnt_q != '1)) ? fail_cnt_q + CNT_W'(1) : fail_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         settle_q   <= '0;
         xpct_q     <= '0;
         mask_q     <= '0;
         last_q     <= 1'b0;
         dut_pi_q   <= '0;
         pat_cnt_q  <= '0;
         fail_cnt_q <= '0;
         ff_pat_q   <= '0;
         ff_bits_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  pat_cnt_q  <= '0;
                  fail_cnt_q <= '0;
                  ff_pat_q   <= '0;
                  ff_bits_q  <= '0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
                  ready_q    <= 1'b1;
                  state_q    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (pat_valid) begin
                  dut_pi_q <= pat_pi;
                  xpct_q   <= pat_xpct;
                  mask_q   <= pat_mask;
                  last_q   <= pat_last;
                  settle_q <= SCNT_W'(SETTLE_CYCLES - 1);
                  ready_q  <= 1'b0;
                  state_q  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_q == '0) state_q <= ST_MEASURE;
               else                settle_q <= settle_q - SCNT_W'(1);
            end
            ST_MEASURE: begin
               pat_cnt_q  <= pat_cnt_q + CNT_W'(1);
               fail_cnt_q <= fail_cnt_d;
               // Only the very first failure of the run is captured.
               if (any_fail && (fail_cnt_q == '0)) begin
                  ff_pat_q  <= pat_cnt_q;
                  ff_bits_q <= mism;
               end
               if (last_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (fail_cnt_d == '0);
                  state_q <= ST_DONE;
               end else begin
                  ready_q <= 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign pat_ready       = ready_q;
   assign dut_pi          = dut_pi_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign pat_count       = pat_cnt_q;
   assign fail_count      = fail_cnt_q;
   assign first_fail_pat  = ff_pat_q;
   assign first_fail_bits = ff_bits_q;

endmodule

// File: tb/tb_scan_pattern_player.sv
// tb/tb_scan_pattern_player.sv - directed bench for scan_pattern_player
module tb_scan_pattern_player;

   logic        clk = 1'b0;
   logic        rst_n, start, pat_valid, pat_ready, pat_last;
   logic [4:0]  pat_pi, dut_pi;
   logic [1:0]  pat_xpct, pat_mask, dut_po, first_fail_bits;
   logic        busy, done, pass;
   logic [15:0] pat_count, fail_count, first_fail_pat;
   int          checks = 0;
   int          errors = 0;

   scan_pattern_player #(
      .NINPUTS(5), .NOUTPUTS(2), .SETTLE_CYCLES(4), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_pi(pat_pi),
      .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
      .dut_pi(dut_pi), .dut_po(dut_po), .busy(busy), .done(done), .pass(pass),
      .pat_count(pat_count), .fail_count(fail_count),
      .first_fail_pat(first_fail_pat), .first_fail_bits(first_fail_bits)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic xfer(input logic [4:0] pi, input logic [1:0] xp, input logic [1:0] mk,
                       input logic [1:0] po, input logic last);
      int n = 0;
      while (!pat_ready && n < 50) begin tick(); n++; end
      if (!pat_ready) chk("ready_timeout", 32'd0, 32'd1);
      pat_valid = 1'b1; pat_pi = pi; pat_xpct = xp; pat_mask = mk; pat_last = last;
      dut_po = po;
      tick();
      pat_valid = 1'b0;
   endtask

   task automatic wait_back();
      int n = 0;
      while (!(pat_ready || done) && n < 50) begin tick(); n++; end
      if (!(pat_ready || done)) chk("measure_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [4:0] pi, input logic [1:0] xp, input logic [1:0] mk,
                       input logic [1:0] po, input logic last);
      xfer(pi, xp, mk, po, last);
      wait_back();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; pat_valid = 1'b0; pat_last = 1'b0;
      pat_pi = '0; pat_xpct = '0; pat_mask = '0; dut_po = '0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_ready", pat_ready, 0);
      chk("rst_dut_pi", dut_pi, 0);
      chk("rst_pat_count", pat_count, 0);
      chk("rst_fail_count", fail_count, 0);
      rst_n = 1'b1;
      tick();

      // Passing run
      do_start();
      chk("start_busy", busy, 1);
      chk("start_ready", pat_ready, 1);
      send(5'b11101, 2'b10, 2'b11, 2'b10, 1'b0);
      send(5'b01101, 2'b00, 2'b11, 2'b00, 1'b1);
      chk("p1_done", done, 1);
      chk("p1_busy", busy, 0);
      chk("p1_pass", pass, 1);
      chk("p1_pat_count", pat_count, 2);
      chk("p1_fail_count", fail_count, 0);
      chk("p1_dut_pi", dut_pi, 5'b01101);

      // Single failure on pattern 1
      do_start();
      send(5'b00001, 2'b01, 2'b11, 2'b01, 1'b0);
      send(5'b00010, 2'b01, 2'b11, 2'b11, 1'b0);
      send(5'b00011, 2'b00, 2'b11, 2'b00, 1'b1);
      chk("sf_done", done, 1);
      chk("sf_fail_count", fail_count, 1);
      chk("sf_first_pat", first_fail_pat, 1);
      chk("sf_first_bits", first_fail_bits, 2'b10);
      chk("sf_pass", pass, 0);
      chk("sf_pat_count", pat_count, 3);

      // Mask behaviour
      do_start();
      chk("mk_first_bits_clr", first_fail_bits, 0);
      send(5'b00100, 2'b10, 2'b00, 2'b01, 1'b0);
      chk("mk_zero_mask", fail_count, 0);
      send(5'b10010, 2'b10, 2'b01, 2'b01, 1'b1);
      chk("mk_fail_count", fail_count, 1);
      chk("mk_first_bits", first_fail_bits, 2'b01);
      chk("mk_first_pat", first_fail_pat, 1);

      // Backpressure and measurement timing
      do_start();
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("bp_ready", pat_ready, 1);
         chk("bp_dut_pi", dut_pi, 5'b10010);
      end
      xfer(5'b10101, 2'b11, 2'b11, 2'b00, 1'b1);
      chk("tm_dut_pi", dut_pi, 5'b10101);
      repeat (4) tick();
      dut_po = 2'b11;
      tick();
      dut_po = 2'b00;
      wait_back();
      chk("tm_done", done, 1);
      chk("tm_pass", pass, 1);
      chk("tm_fail_count", fail_count, 0);

      // Reset during settle of pattern 2
      do_start();
      send(5'b00111, 2'b00, 2'b11, 2'b11, 1'b0);
      chk("rm_pre_count", pat_count, 1);
      xfer(5'b01111, 2'b00, 2'b11, 2'b00, 1'b0);
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("rm_busy", busy, 0);
      chk("rm_done", done, 0);
      chk("rm_pat_count", pat_count, 0);
      chk("rm_fail_count", fail_count, 0);
      chk("rm_dut_pi", dut_pi, 0);
      chk("rm_ready", pat_ready, 0);
      tick();
      rst_n = 1'b1;
      tick();
      do_start();
      send(5'b11000, 2'b01, 2'b11, 2'b01, 1'b1);
      chk("rm_new_count", pat_count, 1);
      chk("rm_new_pass", pass, 1);

      // Ignored start while busy, then restart from DONE
      do_start();
      send(5'b00001, 2'b00, 2'b11, 2'b01, 1'b0);
      do_start();
      chk("ig_busy", busy, 1);
      chk("ig_pat_count", pat_count, 1);
      chk("ig_fail_count", fail_count, 1);
      send(5'b00010, 2'b00, 2'b11, 2'b10, 1'b0);
      send(5'b00011, 2'b00, 2'b11, 2'b11, 1'b1);
      chk("rs_fail3", fail_count, 3);
      chk("rs_done_before", done, 1);
      do_start();
      chk("rs_done_drop", done, 0);
      chk("rs_fail_clr", fail_count, 0);
      chk("rs_count_clr", pat_count, 0);
      chk("rs_busy", busy, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scan_pattern_player.md
Name: scan_pattern_player

Overview:
- Hardware pattern applier/checker for the combinational ATPG flow: the on-chip end of the stimulus/compare protocol.
- Accepts a stream of test vectors, each with primary-input values, expected outputs and a compare mask.
- Drives each vector onto the DUT, waits a settle window, samples the DUT outputs and performs a masked compare.
- Reports the fail count, the first failing pattern and the pass/done status; sits between a pattern ROM/loader and the DUT wrapper.

Parameters:
- NINPUTS, 5, number of DUT primary inputs (PI vector width)
- NOUTPUTS, 2, number of DUT primary outputs (PO vector width)
- SETTLE_CYCLES, 4, clock cycles between driving the PIs and measuring the POs; legal range is 1 or greater
- CNT_W, 16, width of the pattern and fail counters

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a run
- pat_valid  in  1  pattern stream valid
- pat_ready  out  1  pattern stream ready
- pat_pi  in  NINPUTS  PI values; bit 0 is PI[0]
- pat_xpct  in  NOUTPUTS  expected PO values
- pat_mask  in  NOUTPUTS  1 = compare this bit
- pat_last  in  1  marks the final pattern of the run
- dut_pi  out  NINPUTS  registered drive to the DUT inputs
- dut_po  in  NOUTPUTS  DUT outputs
- busy  out  1  run in progress
- done  out  1  run complete; held until the next start
- pass  out  1  valid when done=1; 1 if fail_count==0
- pat_count  out  CNT_W  patterns measured this run
- fail_count  out  CNT_W  failing patterns; saturates at all-ones
- first_fail_pat  out  CNT_W  index of the first failing pattern
- first_fail_bits  out  NOUTPUTS  mismatch vector of the first failing pattern

Behaviour:
- Reset values: all outputs are 0, the FSM is in IDLE, and dut_pi is 0.
- FSM states: IDLE, LOAD, SETTLE, MEASURE, DONE.
- IDLE:
  - start=1 clears pat_count, fail_count, first_fail_pat and first_fail_bits, sets busy=1, and moves to LOAD.
- LOAD:
  - pat_ready=1 only in this state.
  - A transfer occurs when pat_valid and pat_ready are both 1 at a clock edge.
  - On that edge, dut_pi is loaded from pat_pi; xpct, mask and last are latched internally; the settle counter is loaded with SETTLE_CYCLES-1; the FSM moves to SETTLE.
  - pat_valid=0 means the FSM waits in LOAD indefinitely; dut_pi holds its previous value.
- SETTLE:
  - The counter decrements each cycle; at 0 the FSM moves to MEASURE.
  - The first measurement therefore occurs SETTLE_CYCLES+1 edges after the transfer edge.
- MEASURE (one cycle):
  - mism = (dut_po ^ xpct) & mask.
  - pat_count increments.
  - If mism != 0 and fail_count == 0, then first_fail_pat = pat_count (the pre-increment value) and first_fail_bits = mism.
  - If mism != 0, fail_count increments, saturating at all-ones.
  - Next state is DONE if last=1, else LOAD.
- DONE:
  - busy=0, done=1, pass=(fail_count==0).
  - All results and dut_pi hold.
  - start=1 restarts the run exactly as from IDLE, and done drops on the same edge.
- start is ignored while busy=1.
- A mask of all zeros can never fail.
- pat_count wraps modulo 2^CNT_W; it is not saturating.
- Asserting rst_n=0 mid-run aborts immediately: all outputs return to their reset values and any partially consumed pattern is discarded.
- No combinational path from dut_po to any output; all outputs are registered.

Decomposition:
- Package scan_player_pkg holds:
  - the FSM state enum (3-bit encoding);
  - a typedef for the pattern record {pi, xpct, mask, last}.
- One sub-module is natural: scan_masked_cmp, which produces the combinational mism vector and an any-fail flag, is reused by the future MISR checker.
- The counters and the FSM stay in the top module.

Test Plan:
- Passing run (SETTLE_CYCLES=4, stub DUT returns the expected value): stream pi=5'b11101 xpct=2'b10 mask=2'b11, then pi=5'b01101 xpct=2'b00 (last) -> done=1, pass=1, pat_count=2, fail_count=0, and dut_pi=5'b01101 at the end.
- Single fail: 3 patterns, with the stub forcing dut_po=2'b11 on pattern 1 where xpct=2'b01 and mask=2'b11 -> fail_count=1, first_fail_pat=1, first_fail_bits=2'b10, pass=0.
- Mask: xpct=2'b10, dut_po=2'b01, mask=2'b00 -> no fail; with mask=2'b01 -> fail_count=1 and first_fail_bits=2'b01.
- Backpressure/timing: hold pat_valid=0 for 7 cycles in LOAD -> pat_ready stays 1 and dut_pi is unchanged. After the transfer, the measurement is exactly 5 edges later (SETTLE_CYCLES=4), checked by sampling a dut_po pulse that is valid only on that cycle.
- Reset mid-run: assert rst_n=0 during SETTLE of pattern 2 -> busy, done, counters and dut_pi are 0 immediately. A new start plus 1 pattern gives pat_count=1.
- Restart and ignored start: pulsing start while busy=1 has no effect. start in DONE clears fail_count from 3 to 0 and drops done on the same edge.
